// File: rtl/tx_nibble_link.sv
// FIFO-buffered word transmitter: serialises each word LSB-first over a BUS_W-bit bus,
// one 4-phase Req/Ack handshake per beat, with a synchronised Req and a phase timeout.
module tx_nibble_link #(
   parameter int DATA_W      = 12,
   parameter int BUS_W       = 4,
   parameter int FIFO_DEPTH  = 4,
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT     = 1024
) (
   input  logic              ExtClk,
   input  logic              ExtReset,
   input  logic              WrEn,
   input  logic [DATA_W-1:0] WrData,
   input  logic              Req,
   input  logic              ErrClr,
   output logic              Ack,
   output logic [BUS_W-1:0]  DataOut,
   output logic              First,
   output logic              Done,
   output logic              Full,
   output logic              Busy,
   output logic              TimeoutErr,
   output logic              OverflowErr
);
   localparam int BEATS = (DATA_W + BUS_W - 1) / BUS_W;
   localparam int SH_W  = BEATS * BUS_W;
   localparam int BC_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [BC_W-1:0] LAST_BEAT = BC_W'(BEATS - 1);
   localparam logic [TW-1:0]   TMO_LAST  = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   localparam logic [AW:0]     DEPTH     = (AW+1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, WAIT_REQ, SETUP, WAIT_REL} state_t;

   state_t                            state_q, state_d;
   logic [SYNC_STAGES-1:0]            req_sync_q, req_sync_d;
   logic [FIFO_DEPTH-1:0][DATA_W-1:0] mem_q, mem_d;
   logic [AW-1:0]                     wr_q, wr_d, rd_q, rd_d;
   logic [AW:0]                       cnt_q, cnt_d;
   logic                              full_q, full_d;
   logic [SH_W-1:0]                   shift_q, shift_d;
   logic [BC_W-1:0]                   beat_q, beat_d;
   logic [TW-1:0]                     tmo_q, tmo_d;
   logic [BUS_W-1:0]                  dout_q, dout_d;
   logic                              ack_q, ack_d, first_q, first_d, done_q, done_d;
   logic                              busy_q, busy_d, tmo_err_q, tmo_err_d, ovf_err_q, ovf_err_d;
   logic                              req_s, push, pop, counting, tmo_exp, tmo_hit;

   assign req_s    = req_sync_q[SYNC_STAGES-1];
   assign push     = WrEn & ~full_q;
   // An idle link parked on beat 0 may wait forever for the first Req.
   assign counting = (state_q == WAIT_REL) || ((state_q == WAIT_REQ) && (beat_q != '0));
   assign tmo_exp  = (TIMEOUT > 0) && counting && (tmo_q == TMO_LAST);

   always_comb begin
      req_sync_d = {req_sync_q[SYNC_STAGES-2:0], Req};
      state_d    = state_q;
      shift_d    = shift_q;
      beat_d     = beat_q;
      dout_d     = dout_q;
      ack_d      = ack_q;
      first_d    = first_q;
      done_d     = 1'b0;
      pop        = 1'b0;
      tmo_hit    = 1'b0;
      case (state_q)
         IDLE: begin
            ack_d = 1'b0;
            if (cnt_q != '0) begin
               pop     = 1'b1;
               shift_d = SH_W'(mem_q[rd_q]);
               beat_d  = '0;
               state_d = WAIT_REQ;
            end
         end
         WAIT_REQ: begin
            if (req_s) begin
               dout_d  = shift_q[BUS_W-1:0];
               first_d = (beat_q == '0);
               state_d = SETUP;
            end else if (tmo_exp) begin
               tmo_hit = 1'b1;
            end
         end
         SETUP: begin
            ack_d   = 1'b1;
            state_d = WAIT_REL;
         end
         WAIT_REL: begin
            if (!req_s) begin
               ack_d = 1'b0;
               if (beat_q == LAST_BEAT) begin
                  done_d  = 1'b1;
                  first_d = 1'b0;
                  state_d = IDLE;
               end else begin
                  shift_d = shift_q >> BUS_W;
                  beat_d  = beat_q + 1'b1;
                  state_d = WAIT_REQ;
               end
            end else if (tmo_exp) begin
               tmo_hit = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      if (tmo_hit) begin
         ack_d   = 1'b0;
         first_d = 1'b0;
         state_d = IDLE;
      end
      tmo_d  = (counting && (state_d == state_q)) ? tmo_q + 1'b1 : '0;
      busy_d = (state_d != IDLE);

      mem_d = mem_q;
      if (push) mem_d[wr_q] = WrData;
      wr_d   = push ? wr_q + 1'b1 : wr_q;
      rd_d   = pop ? rd_q + 1'b1 : rd_q;
      cnt_d  = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
      full_d = (cnt_d == DEPTH);

      // Set beats clear when both land in the same cycle.
      tmo_err_d = (tmo_err_q & ~ErrClr) | tmo_hit;
      ovf_err_d = (ovf_err_q & ~ErrClr) | (WrEn & full_q);
   end

   always_ff @(posedge ExtClk or posedge ExtReset) begin
      if (ExtReset) begin
         state_q    <= IDLE;
         req_sync_q <= '0;
         mem_q      <= '0;
         wr_q       <= '0;
         rd_q       <= '0;
         cnt_q      <= '0;
         full_q     <= 1'b0;
         shift_q    <= '0;
         beat_q     <= '0;
         tmo_q      <= '0;
         dout_q     <= '0;
         ack_q      <= 1'b0;
         first_q    <= 1'b0;
         done_q     <= 1'b0;
         busy_q     <= 1'b0;
         tmo_err_q  <= 1'b0;
         ovf_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         req_sync_q <= req_sync_d;
         mem_q      <= mem_d;
         wr_q       <= wr_d;
         rd_q       <= rd_d;
         cnt_q      <= cnt_d;
         full_q     <= full_d;
         shift_q    <= shift_d;
         beat_q     <= beat_d;
         tmo_q      <= tmo_d;
         dout_q     <= dout_d;
         ack_q      <= ack_d;
         first_q    <= first_d;
         done_q     <= done_d;
         busy_q     <= busy_d;
         tmo_err_q  <= tmo_err_d;
         ovf_err_q  <= ovf_err_d;
      end
   end

   assign Ack         = ack_q;
   assign DataOut     = dout_q;
   assign First       = first_q;
   assign Done        = done_q;
   assign Full        = full_q;
   assign Busy        = busy_q;
   assign TimeoutErr  = tmo_err_q;
   assign OverflowErr = ovf_err_q;
endmodule

// File: tb/tb_tx_nibble_link.sv
// Scoreboard bench for tx_nibble_link (DATA_W=10 so the last beat exercises padding).
module tb_tx_nibble_link;
   localparam int DATA_W = 10, BUS_W = 4, FIFO_DEPTH = 4, SYNC_STAGES = 2, TIMEOUT = 16;
   // Edges counted from the first edge that samples the Req change:
   // rise: ReqS up after SYNC_STAGES-1 more edges, SETUP next, Ack the edge after.
   // fall: ReqS down after SYNC_STAGES-1 more edges, Ack drops on the next one.
   localparam int RISE_LAT = SYNC_STAGES + 1;
   localparam int FALL_LAT = SYNC_STAGES;

   logic              clk = 1'b0, rst = 1'b1, wr_en = 1'b0, req = 1'b0, err_clr = 1'b0;
   logic [DATA_W-1:0] wr_data = '0;
   logic              ack, first, done, full, busy, tmo_err, ovf_err;
   logic [BUS_W-1:0]  dout;
   logic              esp_en = 1'b0, req_man = 1'b0;
   int                total = 0, bad = 0, done_cnt = 0, cyc = 0;
   logic [4:0]        exp_q[$];

   logic              m_ack_p = 1'b0, m_req_p = 1'b0, m_pend_r = 1'b0, m_pend_f = 1'b0;
   logic [BUS_W-1:0]  m_dout_p = '0;
   int                m_rise_c = 0, m_fall_c = 0;
   logic [4:0]        m_e;

   tx_nibble_link #(.DATA_W(DATA_W), .BUS_W(BUS_W), .FIFO_DEPTH(FIFO_DEPTH),
                    .SYNC_STAGES(SYNC_STAGES), .TIMEOUT(TIMEOUT)) dut (
      .ExtClk(clk), .ExtReset(rst), .WrEn(wr_en), .WrData(wr_data), .Req(req),
      .ErrClr(err_clr), .Ack(ack), .DataOut(dout), .First(first), .Done(done),
      .Full(full), .Busy(busy), .TimeoutErr(tmo_err), .OverflowErr(ovf_err));

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Called at a negedge; queues the n beats the ESP should see for this word.
   task automatic push(input logic [DATA_W-1:0] w, input logic [3:0] b0, b1, b2, input int n);
      if (n > 0) exp_q.push_back({1'b1, b0});
      if (n > 1) exp_q.push_back({1'b0, b1});
      if (n > 2) exp_q.push_back({1'b0, b2});
      wr_en   = 1'b1;
      wr_data = w;
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   task automatic wait_ack(input logic v);
      int n = 0;
      while (ack !== v && n < 100) begin @(negedge clk); n++; end
      check("ack_wait", 32'(ack), 32'(v));
   endtask

   task automatic wait_done(input int target);
      int n = 0;
      while (done_cnt < target && n < 1000) begin @(negedge clk); n++; end
      check("done_count", 32'(done_cnt), 32'(target));
   endtask

   task automatic man_beat();
      req_man = 1'b1; wait_ack(1'b1);
      req_man = 1'b0; wait_ack(1'b0);
   endtask

   task automatic esp_quiet();
      esp_en = 1'b0; req_man = 1'b0;
      repeat (5) @(negedge clk);
   endtask

   // ESP model: auto mode answers each Ack edge on the next negedge.
   initial forever begin
      @(negedge clk);
      if (esp_en) begin
         if (!req && !ack) req = 1'b1;
         else if (req && ack) req = 1'b0;
      end else req = req_man;
   end

   // Monitor: every Ack rise is a beat presented to the ESP.
   initial forever begin
      @(posedge clk); #1;
      cyc++;
      if (rst) begin
         m_pend_r = 1'b0; m_pend_f = 1'b0;
      end else begin
         if (req && !m_req_p && busy && !ack) begin m_pend_r = 1'b1; m_rise_c = cyc; end
         if (!req && m_req_p && ack) begin m_pend_f = 1'b1; m_fall_c = cyc; end
         if (ack && !m_ack_p) begin
            if (exp_q.size() == 0) check("unexpected_beat", 32'd1, 32'd0);
            else begin
               m_e = exp_q.pop_front();
               check("beat_data", 32'(dout), 32'(m_e[3:0]));
               check("beat_first", 32'(first), 32'(m_e[4]));
            end
            check("data_setup", 32'(m_dout_p), 32'(dout));
            if (m_pend_r) check("ack_rise_lat", 32'(cyc - m_rise_c), 32'(RISE_LAT));
            m_pend_r = 1'b0;
         end
         if (!ack && m_ack_p) begin
            if (m_pend_f) check("ack_fall_lat", 32'(cyc - m_fall_c), 32'(FALL_LAT));
            m_pend_f = 1'b0;
         end
         if (done) done_cnt++;
      end
      m_ack_p = ack; m_req_p = req; m_dout_p = dout;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int base, gaps, n;
      logic started;
      repeat (3) @(negedge clk);
      check("rst_ack", 32'(ack), 0);   check("rst_dout", 32'(dout), 0);
      check("rst_first", 32'(first), 0); check("rst_done", 32'(done), 0);
      check("rst_full", 32'(full), 0); check("rst_busy", 32'(busy), 0);
      check("rst_tmo", 32'(tmo_err), 0); check("rst_ovf", 32'(ovf_err), 0);
      rst = 1'b0;

      // Basic word, manual 4-phase handshake
      push(10'h2BC, 4'hC, 4'hB, 4'h2, 3);
      repeat (3) man_beat();
      repeat (2) @(negedge clk);
      check("basic_done", 32'(done_cnt), 1);
      check("basic_busy", 32'(busy), 0);
      check("basic_first_clr", 32'(first), 0);
      check("basic_dout_hold", 32'(dout), 32'h2);

      // Padding in the last beat
      esp_en = 1'b1;
      push(10'h3FF, 4'hF, 4'hF, 4'h3, 3);
      push(10'h155, 4'h5, 4'h5, 4'h1, 3);
      wait_done(3);

      // Back-to-back words
      base = done_cnt; gaps = 0; started = 1'b0; n = 0;
      push(10'h2A1, 4'h1, 4'hA, 4'h2, 3);
      push(10'h0F0, 4'h0, 4'hF, 4'h0, 3);
      push(10'h35C, 4'hC, 4'h5, 4'h3, 3);
      while (done_cnt < base + 3 && n < 1000) begin
         @(negedge clk); n++;
         if (busy) started = 1'b1;
         else if (started && done_cnt < base + 3) gaps++;
      end
      check("b2b_done", 32'(done_cnt), 32'(base + 3));
      check("b2b_idle_gaps", 32'(gaps), 2);
      check("b2b_tmo", 32'(tmo_err), 0);
      check("b2b_ovf", 32'(ovf_err), 0);

      // Overflow: head is popped, four more fill the FIFO, sixth is dropped
      esp_quiet();
      base = done_cnt;
      push(10'h001, 4'h1, 4'h0, 4'h0, 3);
      push(10'h002, 4'h2, 4'h0, 4'h0, 3);
      push(10'h003, 4'h3, 4'h0, 4'h0, 3);
      push(10'h004, 4'h4, 4'h0, 4'h0, 3);
      push(10'h005, 4'h5, 4'h0, 4'h0, 3);
      check("ovf_full", 32'(full), 1);
      check("ovf_pre_err", 32'(ovf_err), 0);
      push(10'h006, 4'h6, 4'h0, 4'h0, 0);
      check("ovf_err", 32'(ovf_err), 1);
      check("ovf_full_hold", 32'(full), 1);
      esp_en = 1'b1;
      wait_done(base + 5);
      check("ovf_drained_full", 32'(full), 0);
      check("ovf_sticky", 32'(ovf_err), 1);
      err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
      check("ovf_clr", 32'(ovf_err), 0);

      // Timeout: Req held high after beat 0
      esp_quiet();
      base = done_cnt;
      push(10'h123, 4'h3, 4'h2, 4'h1, 1);
      req_man = 1'b1;
      wait_ack(1'b1);
      n = 0;
      while (ack && n < 40) begin @(negedge clk); n++; end
      check("tmo_cycles", 32'(n), 32'(TIMEOUT));
      check("tmo_err", 32'(tmo_err), 1);
      check("tmo_busy", 32'(busy), 0);
      check("tmo_first", 32'(first), 0);
      check("tmo_no_done", 32'(done_cnt), 32'(base));
      req_man = 1'b0;
      repeat (5) @(negedge clk);
      esp_en = 1'b1;
      push(10'h256, 4'h6, 4'h5, 4'h2, 3);
      wait_done(base + 1);
      check("tmo_sticky", 32'(tmo_err), 1);
      err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
      check("tmo_clr", 32'(tmo_err), 0);

      // Reset during WAIT_REL of beat 1
      esp_quiet();
      base = done_cnt;
      push(10'h1E7, 4'h7, 4'hE, 4'h1, 2);
      man_beat();
      req_man = 1'b1;
      wait_ack(1'b1);
      #2 rst = 1'b1;
      #1;
      check("mid_rst_ack", 32'(ack), 0);   check("mid_rst_dout", 32'(dout), 0);
      check("mid_rst_first", 32'(first), 0); check("mid_rst_busy", 32'(busy), 0);
      check("mid_rst_full", 32'(full), 0);
      req_man = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("mid_rst_no_done", 32'(done_cnt), 32'(base));
      esp_en = 1'b1;
      push(10'h389, 4'h9, 4'h8, 4'h3, 3);
      wait_done(base + 1);

      repeat (4) @(negedge clk);
      check("exp_drained", 32'(exp_q.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
